hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32I core.
- Watches the decode-stage source registers against the EX/MEM/WB destinations.
- Drives the ID-stage operand-forwarding selects.
- Inserts load-use bubbles (multi-cycle when DRAM latency requires) and flushes IF/ID and ID/EX on EX-resolved redirects.
- Keeps saturating stall/flush performance counters.

---
 rtl/core_pkg.sv | 25 ++
 rtl/hazard_fwd_sel.sv | 30 +++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I core: operand-forward selects, hazard FSM
// states and the register-file write-back source codes.
package core_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_t;

  // rf_wesl write-back source; DRAM marks a load whose data arrives late
  localparam logic [1:0] WESL_ALU  = 2'b00;
  localparam logic [1:0] WESL_DRAM = 2'b01;
  localparam logic [1:0] WESL_PC4  = 2'b10;
  localparam logic [1:0] WESL_IMM  = 2'b11;

  function automatic logic is_load(input logic [1:0] wesl);
    return wesl == WESL_DRAM;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority matcher choosing the operand source for one decode-stage register.
module hazard_fwd_sel
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       re,
  input  logic [4:0] ex_wr,
  input  logic       ex_we,
  input  logic       ex_is_load,
  input  logic [4:0] mem_wr,
  input  logic       mem_we,
  input  logic [4:0] wb_wr,
  input  logic       wb_we,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (re && rs != 5'd0) begin
      // a load in EX has no data yet; the stall path covers it
      if (ex_we && ex_wr == rs)
        sel = ex_is_load ? FWD_RF : FWD_EX;
      else if (mem_we && mem_wr == rs)
        sel = FWD_MEM;
      else if (wb_we && wb_wr == rs)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: operand forwarding, load-use bubbles,
// redirect flushes and saturating stall/flush performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wr,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_wr,
  input  logic             mem_we,
  input  logic [4:0]       wb_wr,
  input  logic             wb_we,
  input  logic             ex_redirect,
  input  logic             perf_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t  state, state_nxt;
  logic [2:0] remain, remain_nxt;
  logic [1:0] sel_a, sel_b;
  logic       load_use, stall_inc, flush_inc;

  hazard_fwd_sel u_fwd_a (
    .rs(id_rs1), .re(id_re1),
    .ex_wr(ex_wr), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_wr(mem_wr), .mem_we(mem_we), .wb_wr(wb_wr), .wb_we(wb_we),
    .sel(sel_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs(id_rs2), .re(id_re2),
    .ex_wr(ex_wr), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_wr(mem_wr), .mem_we(mem_we), .wb_wr(wb_wr), .wb_we(wb_we),
    .sel(sel_b)
  );

  assign fwd_a = rst ? FWD_RF : sel_a;
  assign fwd_b = rst ? FWD_RF : sel_b;

  assign load_use = ex_is_load && ex_we && ex_wr != 5'd0 &&
                    ((id_re1 && id_rs1 == ex_wr) || (id_re2 && id_rs2 == ex_wr));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    state_nxt  = state;
    remain_nxt = remain;
    // a redirect always wins, even over an in-progress load bubble
    if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      state_nxt  = ST_RUN;
      remain_nxt = 3'd0;
    end else if (state == ST_STALL) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      remain_nxt = remain - 3'd1;
      if (remain == 3'd1) state_nxt = ST_RUN;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      if (LOAD_STALL > 1) begin
        state_nxt  = ST_STALL;
        remain_nxt = 3'(LOAD_STALL - 1);
      end
    end
    if (rst) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      remain    <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      if (perf_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
        if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations share one stimulus stream and
// are checked every cycle against a bubble-count model plus literal expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_wr, mem_wr, wb_wr;
  logic       id_re1, id_re2, ex_we, ex_is_load, mem_we, wb_we, ex_redirect, perf_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instance 0: LOAD_STALL=1, instance 1: LOAD_STALL=3, instance 2: LOAD_STALL=1 with 4-bit counters
  localparam int LS [3] = '{1, 3, 1};
  localparam int CW [3] = '{32, 32, 4};

  logic [1:0]  a_fa [3];
  logic [1:0]  a_fb [3];
  logic        a_ps [3];
  logic        a_is [3];
  logic        a_if [3];
  logic        a_xf [3];
  logic [31:0] a_sc [3];
  logic [31:0] a_fc [3];
  logic [3:0]  d4_sc, d4_fc;

  hazard_ctrl #(.LOAD_STALL(1), .CNT_W(32)) d1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wr(ex_wr), .ex_we(ex_we), .ex_is_load(ex_is_load), .mem_wr(mem_wr), .mem_we(mem_we),
    .wb_wr(wb_wr), .wb_we(wb_we), .ex_redirect(ex_redirect), .perf_clr(perf_clr),
    .fwd_a(a_fa[0]), .fwd_b(a_fb[0]), .pc_stall(a_ps[0]), .ifid_stall(a_is[0]),
    .ifid_flush(a_if[0]), .idex_flush(a_xf[0]), .stall_cnt(a_sc[0]), .flush_cnt(a_fc[0]));

  hazard_ctrl #(.LOAD_STALL(3), .CNT_W(32)) d3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wr(ex_wr), .ex_we(ex_we), .ex_is_load(ex_is_load), .mem_wr(mem_wr), .mem_we(mem_we),
    .wb_wr(wb_wr), .wb_we(wb_we), .ex_redirect(ex_redirect), .perf_clr(perf_clr),
    .fwd_a(a_fa[1]), .fwd_b(a_fb[1]), .pc_stall(a_ps[1]), .ifid_stall(a_is[1]),
    .ifid_flush(a_if[1]), .idex_flush(a_xf[1]), .stall_cnt(a_sc[1]), .flush_cnt(a_fc[1]));

  hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4)) d4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wr(ex_wr), .ex_we(ex_we), .ex_is_load(ex_is_load), .mem_wr(mem_wr), .mem_we(mem_we),
    .wb_wr(wb_wr), .wb_we(wb_we), .ex_redirect(ex_redirect), .perf_clr(perf_clr),
    .fwd_a(a_fa[2]), .fwd_b(a_fb[2]), .pc_stall(a_ps[2]), .ifid_stall(a_is[2]),
    .ifid_flush(a_if[2]), .idex_flush(a_xf[2]), .stall_cnt(d4_sc), .flush_cnt(d4_fc));

  assign a_sc[2] = {28'd0, d4_sc};
  assign a_fc[2] = {28'd0, d4_fc};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_left [3];
  longint m_sc   [3];
  longint m_fc   [3];
  int     n_left [3];
  longint n_sc   [3];
  longint n_fc   [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      n_left[i] = 0; n_sc[i] = 0; n_fc[i] = 0;
    end
  end

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic re);
    logic [4:0] wr [3];
    logic       we [3];
    wr = '{ex_wr, mem_wr, wb_wr};
    we = '{ex_we, mem_we, wb_we};
    if (!re || rs == 5'd0) return 2'd0;
    for (int s = 0; s < 3; s++)
      if (we[s] && wr[s] == rs) return (s == 0 && ex_is_load) ? 2'd0 : 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic longint bump(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [1:0] efa, efb;
      logic       eps, eif, exf, lu, st, fl;
      efa = m_fwd(id_rs1, id_re1);
      efb = m_fwd(id_rs2, id_re2);
      lu  = ex_is_load && ex_we && ex_wr != 0 &&
            ((id_re1 && id_rs1 == ex_wr) || (id_re2 && id_rs2 == ex_wr));
      st = 1'b0; fl = 1'b0;
      n_left[i] = m_left[i];
      if (ex_redirect) begin
        fl = 1'b1; n_left[i] = 0;
      end else if (m_left[i] > 0) begin
        st = 1'b1; n_left[i] = m_left[i] - 1;
      end else if (lu) begin
        st = 1'b1; n_left[i] = LS[i] - 1;
      end
      if (perf_clr) begin
        n_sc[i] = 0; n_fc[i] = 0;
      end else begin
        n_sc[i] = st ? bump(m_sc[i], CW[i]) : m_sc[i];
        n_fc[i] = fl ? bump(m_fc[i], CW[i]) : m_fc[i];
      end
      eps = st; eif = fl; exf = st | fl;
      if (rst) begin
        efa = 0; efb = 0; eps = 0; eif = 0; exf = 0;
        n_left[i] = 0; n_sc[i] = 0; n_fc[i] = 0;
      end
      chk($sformatf("d%0d fwd_a", i), 64'(a_fa[i]), 64'(efa));
      chk($sformatf("d%0d fwd_b", i), 64'(a_fb[i]), 64'(efb));
      chk($sformatf("d%0d pc_stall", i), 64'(a_ps[i]), 64'(eps));
      chk($sformatf("d%0d ifid_stall", i), 64'(a_is[i]), 64'(eps));
      chk($sformatf("d%0d ifid_flush", i), 64'(a_if[i]), 64'(eif));
      chk($sformatf("d%0d idex_flush", i), 64'(a_xf[i]), 64'(exf));
      chk($sformatf("d%0d stall_cnt", i), 64'(a_sc[i]), 64'(m_sc[i]));
      chk($sformatf("d%0d flush_cnt", i), 64'(a_fc[i]), 64'(m_fc[i]));
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_left[i] <= 0; m_sc[i] <= 0; m_fc[i] <= 0;
      end else begin
        m_left[i] <= n_left[i]; m_sc[i] <= n_sc[i]; m_fc[i] <= n_fc[i];
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0;
    ex_wr = 0; ex_we = 0; ex_is_load = 0;
    mem_wr = 0; mem_we = 0; wb_wr = 0; wb_we = 0;
    ex_redirect = 0; perf_clr = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_r3();
    ex_is_load = 1; ex_we = 1; ex_wr = 5'd3; id_rs1 = 5'd3; id_re1 = 1;
  endtask

  initial begin
    int run;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc_stall", 64'(a_ps[1]), 64'd0);
    chk("reset stall_cnt", 64'(a_sc[1]), 64'd0);
    next_cycle();
    rst = 0;

    // WB forward on rs1
    next_cycle(); idle();
    id_rs1 = 5'd5; id_re1 = 1; wb_wr = 5'd5; wb_we = 1;
    @(negedge clk);
    chk("wb fwd_a", 64'(a_fa[0]), 64'd3);
    chk("wb fwd_b", 64'(a_fb[0]), 64'd0);
    chk("wb no stall", 64'(a_ps[0]), 64'd0);

    // EX beats MEM on rs2; x0 never forwarded
    next_cycle(); idle();
    id_rs2 = 5'd7; id_re2 = 1; ex_wr = 5'd7; ex_we = 1; mem_wr = 5'd7; mem_we = 1;
    @(negedge clk);
    chk("prio fwd_b", 64'(a_fb[0]), 64'd1);
    next_cycle();
    id_rs2 = 5'd0; ex_wr = 5'd0; mem_wr = 5'd0;
    @(negedge clk);
    chk("x0 fwd_b", 64'(a_fb[0]), 64'd0);

    // load-use with single bubble, then the load sits in MEM
    next_cycle(); idle(); load_use_r3();
    @(negedge clk);
    chk("lu1 pc_stall", 64'(a_ps[0]), 64'd1);
    chk("lu1 idex_flush", 64'(a_xf[0]), 64'd1);
    next_cycle(); idle();
    id_rs1 = 5'd3; id_re1 = 1; mem_wr = 5'd3; mem_we = 1;
    @(negedge clk);
    chk("lu1 mem fwd_a", 64'(a_fa[0]), 64'd2);
    chk("lu1 released", 64'(a_ps[0]), 64'd0);
    chk("lu1 stall_cnt", 64'(a_sc[0]), 64'd1);

    // triple bubble: count consecutive stall cycles
    next_cycle(); idle(); perf_clr = 1;
    repeat (3) next_cycle();
    idle(); load_use_r3();
    run = 0;
    @(negedge clk); if (a_ps[1]) run++;
    next_cycle(); idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); if (a_ps[1]) run++;
      next_cycle();
    end
    chk("lu3 stall cycles", 64'(run), 64'd3);
    @(negedge clk);
    chk("lu3 stall_cnt", 64'(a_sc[1]), 64'd3);

    // reset during the second bubble
    next_cycle(); load_use_r3();
    next_cycle(); idle(); rst = 1;
    @(negedge clk);
    chk("rst mid-stall pc_stall", 64'(a_ps[1]), 64'd0);
    chk("rst mid-stall stall_cnt", 64'(a_sc[1]), 64'd0);
    next_cycle(); rst = 0;
    @(negedge clk);
    chk("post-rst no bubble", 64'(a_ps[1]), 64'd0);

    // redirect together with load-use
    next_cycle(); idle(); load_use_r3(); ex_redirect = 1;
    @(negedge clk);
    chk("redir ifid_flush", 64'(a_if[0]), 64'd1);
    chk("redir idex_flush", 64'(a_xf[0]), 64'd1);
    chk("redir pc_stall", 64'(a_ps[0]), 64'd0);
    next_cycle(); idle();
    @(negedge clk);
    chk("redir flush_cnt", 64'(a_fc[0]), 64'd1);
    chk("redir stall_cnt", 64'(a_sc[0]), 64'd0);

    // redirect while in the bubble sequence
    next_cycle(); load_use_r3();
    next_cycle(); idle(); ex_redirect = 1;
    @(negedge clk);
    chk("stall abort flush", 64'(a_if[1]), 64'd1);
    chk("stall abort pc_stall", 64'(a_ps[1]), 64'd0);
    next_cycle(); idle();
    @(negedge clk);
    chk("stall abort run", 64'(a_ps[1]), 64'd0);

    // saturation of the 4-bit counter
    next_cycle(); perf_clr = 1;
    next_cycle(); idle(); load_use_r3();
    repeat (20) next_cycle();
    idle();
    @(negedge clk);
    chk("sat d4 stall_cnt", 64'(a_sc[2]), 64'd15);
    chk("nosat d1 stall_cnt", 64'(a_sc[0]), 64'd20);
    next_cycle(); load_use_r3(); perf_clr = 1;
    next_cycle(); idle();
    @(negedge clk);
    chk("clr beats inc", 64'(a_sc[2]), 64'd0);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
